// File: rtl/node_input_buffer_if.sv
// Handshake bundle between an upstream link, one node_input_buffer and the router lane.
// master is the upstream/router side, slave is the buffer itself.
interface node_input_buffer_if #(
  parameter int stream_width = 144,
  parameter int net_width    = 4,
  parameter int ptr_width    = 2
);
  logic                    in_valid;
  logic [stream_width-1:0] in_flit;
  logic                    in_ready;
  logic [stream_width-1:0] out_stream;
  logic                    out_valid;
  logic                    out_ready;
  logic [net_width-1:0]    out_naddr;
  logic                    credit_out;
  logic [ptr_width:0]      count;

  modport master (
    output in_valid, in_flit, out_ready,
    input  in_ready, out_stream, out_valid, out_naddr, credit_out, count
  );

  modport slave (
    input  in_valid, in_flit, out_ready,
    output in_ready, out_stream, out_valid, out_naddr, credit_out, count
  );
endinterface

// File: rtl/node_input_buffer.sv
// Per-port ingress FIFO ahead of the node router: registered head flit, zeroed lane when empty,
// one credit pulse per dequeue. EMPTY/PARTIAL/FULL are implied by count rather than held in a state register.
module node_input_buffer #(
  parameter int stream_width = 144,
  parameter int net_width    = 4,
  parameter int depth        = 4,
  parameter int ptr_width    = 2
) (
  input logic                clk,
  input logic                rst,
  node_input_buffer_if.slave bus
);
  localparam logic [ptr_width:0] full_count = (ptr_width+1)'(depth);

  logic [stream_width-1:0] mem [depth];
  logic [ptr_width-1:0]    wr_ptr;
  logic [ptr_width-1:0]    rd_ptr;
  logic [ptr_width-1:0]    rd_ptr_next;
  logic [ptr_width:0]      count_q;
  logic [ptr_width:0]      count_left;
  logic [ptr_width:0]      count_next;
  logic [stream_width-1:0] head_next;
  logic [stream_width-1:0] stream_q;
  logic [net_width-1:0]    naddr_q;
  logic                    valid_q;
  logic                    credit_q;
  logic                    push;
  logic                    pop;

  assign bus.in_ready   = (count_q != full_count);
  assign push           = bus.in_valid & bus.in_ready;
  assign pop            = bus.out_ready & valid_q;
  assign bus.count      = count_q;
  assign bus.out_stream = stream_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_naddr  = naddr_q;
  assign bus.credit_out = credit_q;

  // The head after this edge is either an already-stored entry or, if nothing
  // else remains, the flit being written on this same edge.
  always_comb begin
    count_left  = count_q - (ptr_width+1)'(pop);
    count_next  = count_left + (ptr_width+1)'(push);
    rd_ptr_next = rd_ptr + ptr_width'(pop);
    head_next   = '0;
    if (count_left != '0) begin
      head_next = mem[rd_ptr_next];
    end else if (push) begin
      head_next = bus.in_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      stream_q <= '0;
      naddr_q  <= '0;
      valid_q  <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_width'(1);
      end
      rd_ptr   <= rd_ptr_next;
      count_q  <= count_next;
      stream_q <= head_next;
      naddr_q  <= head_next[stream_width-1 -: net_width];
      valid_q  <= (count_next != '0);
      credit_q <= pop;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= bus.in_flit;
    end
  end
endmodule

// File: tb/tb_node_input_buffer.sv
// Directed bench for node_input_buffer: reset, single flit, fill/drain, streaming, wrap, mid-run reset.
module tb_node_input_buffer;
  localparam int SW = 144;
  localparam int NW = 4;
  localparam int D  = 4;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  node_input_buffer_if #(.stream_width(SW), .net_width(NW), .ptr_width(PW)) bus ();
  node_input_buffer #(.stream_width(SW), .net_width(NW), .depth(D), .ptr_width(PW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] mk(input logic [3:0] id);
    return {id, {35{id}}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_flit = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_stream !== '0) $display("FAIL reset_stream got %h want 0", bus.out_stream); else passed++;
    total++; if (bus.count !== 3'd0) $display("FAIL reset_count got %0d want 0", bus.count); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); else passed++;
    total++; if (bus.credit_out !== 1'b0) $display("FAIL reset_credit got %0b want 0", bus.credit_out); else passed++;
  endtask

  task automatic test_single();
    logic [SW-1:0] f;
    f = {4'hA, 140'b0};
    bus.in_valid = 1'b1;
    bus.in_flit = f;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) $display("FAIL single_valid got %0b want 1", bus.out_valid); else passed++;
    total++; if (bus.out_naddr !== 4'hA) $display("FAIL single_naddr got %h want a", bus.out_naddr); else passed++;
    total++; if (bus.out_stream !== f) $display("FAIL single_stream got %h want %h", bus.out_stream, f); else passed++;
    total++; if (bus.count !== 3'd1) $display("FAIL single_count got %0d want 1", bus.count); else passed++;
    total++; if (bus.credit_out !== 1'b0) $display("FAIL single_no_early_credit got %0b want 0", bus.credit_out); else passed++;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++; if (bus.count !== 3'd0) $display("FAIL single_pop_count got %0d want 0", bus.count); else passed++;
    total++; if (bus.out_stream !== '0) $display("FAIL single_pop_stream got %h want 0", bus.out_stream); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL single_pop_valid got %0b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_naddr !== 4'h0) $display("FAIL single_pop_naddr got %h want 0", bus.out_naddr); else passed++;
    total++; if (bus.credit_out !== 1'b1) $display("FAIL single_credit got %0b want 1", bus.credit_out); else passed++;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++; if (bus.credit_out !== 1'b0) $display("FAIL single_credit_width got %0b want 0", bus.credit_out); else passed++;
    total++; if (bus.count !== 3'd0) $display("FAIL empty_pop_count got %0d want 0", bus.count); else passed++;
  endtask

  task automatic test_fill();
    int credits;
    credits = 0;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_flit = mk(4'(i));
      step();
    end
    total++; if (bus.count !== 3'd4) $display("FAIL fill_count got %0d want 4", bus.count); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL fill_in_ready got %0b want 0", bus.in_ready); else passed++;
    bus.in_flit = mk(4'd5);
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.count !== 3'd4) $display("FAIL fill_overflow_count got %0d want 4", bus.count); else passed++;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++; if (bus.out_stream !== mk(4'(i))) $display("FAIL fill_head%0d got %h want %h", i, bus.out_stream, mk(4'(i))); else passed++;
      step();
      if (bus.credit_out === 1'b1) credits++;
    end
    bus.out_ready = 1'b0;
    total++; if (credits != 4) $display("FAIL fill_credits got %0d want 4", credits); else passed++;
    total++; if (bus.count !== 3'd0) $display("FAIL drain_count got %0d want 0", bus.count); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL drain_valid got %0b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_streaming();
    int got[$];
    int credits;
    int maxcnt;
    int gaps;
    int bad;
    credits = 0;
    maxcnt = 0;
    gaps = 0;
    bad = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 10) begin
        bus.in_valid = 1'b1;
        bus.in_flit = mk(4'(c + 1));
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid === 1'b1) got.push_back(int'(bus.out_naddr));
      else if (got.size() > 0 && got.size() < 10) gaps++;
      step();
      if (bus.credit_out === 1'b1) credits++;
      if (int'(bus.count) > maxcnt) maxcnt = int'(bus.count);
    end
    bus.out_ready = 1'b0;
    total++; if (got.size() != 10) $display("FAIL stream_outputs got %0d want 10", got.size()); else passed++;
    foreach (got[i]) if (got[i] != i + 1) bad++;
    total++; if (bad != 0) $display("FAIL stream_order got %0d misordered want 0", bad); else passed++;
    total++; if (credits != 10) $display("FAIL stream_credits got %0d want 10", credits); else passed++;
    total++; if (maxcnt > 1) $display("FAIL stream_max_count got %0d want <=1", maxcnt); else passed++;
    total++; if (gaps != 0) $display("FAIL stream_gaps got %0d want 0", gaps); else passed++;
  endtask

  task automatic test_wrap();
    logic [3:0] ids [7];
    ids = '{4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd1, 4'd2};
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_flit = mk(ids[i]);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.out_naddr !== ids[i]) $display("FAIL wrap_pop%0d got %h want %h", i, bus.out_naddr, ids[i]); else passed++;
      step();
    end
    bus.out_ready = 1'b0;
    for (int i = 3; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_flit = mk(ids[i]);
      step();
    end
    bus.in_valid = 1'b0;
    total++; if (bus.count !== 3'd4) $display("FAIL wrap_count got %0d want 4", bus.count); else passed++;
    bus.out_ready = 1'b1;
    for (int i = 3; i < 7; i++) begin
      total++; if (bus.out_stream !== mk(ids[i])) $display("FAIL wrap_head%0d got %h want %h", i, bus.out_stream, mk(ids[i])); else passed++;
      step();
    end
    bus.out_ready = 1'b0;
    total++; if (bus.count !== 3'd0) $display("FAIL wrap_drain_count got %0d want 0", bus.count); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 3; i <= 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_flit = mk(4'(i));
      step();
    end
    total++; if (bus.count !== 3'd3) $display("FAIL mid_pre_count got %0d want 3", bus.count); else passed++;
    rst = 1'b1;
    bus.in_flit = mk(4'd9);
    bus.out_ready = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    total++; if (bus.count !== 3'd0) $display("FAIL mid_count got %0d want 0", bus.count); else passed++;
    total++; if (bus.out_stream !== '0) $display("FAIL mid_stream got %h want 0", bus.out_stream); else passed++;
    total++; if (bus.credit_out !== 1'b0) $display("FAIL mid_credit got %0b want 0", bus.credit_out); else passed++;
    step();
    total++; if (bus.credit_out !== 1'b0) $display("FAIL mid_credit_after got %0b want 0", bus.credit_out); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_valid_after got %0b want 0", bus.out_valid); else passed++;
    bus.in_valid = 1'b1;
    bus.in_flit = mk(4'd6);
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_stream !== mk(4'd6)) $display("FAIL mid_new_head got %h want %h", bus.out_stream, mk(4'd6)); else passed++;
    total++; if (bus.count !== 3'd1) $display("FAIL mid_new_count got %0d want 1", bus.count); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_streaming();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/node_input_buffer.md
Name: node_input_buffer

Overview:
- Per-port ingress stage placed directly upstream of the node router. One instance sits on each of the five router input streams.
- Buffers incoming flits in a small FIFO and presents the head flit on the router's in_stream lane.
- Drives the lane to all-zero when it holds no flit. The router has no valid qualifier, so an empty lane must never carry stale data.
- Returns one credit pulse per dequeued flit to the upstream link.

Parameters:
- stream_width, 144: flit width in bits. Bits [stream_width-1:stream_width-net_width] are the routing address.
- net_width, 4: width of the address field at the top of the flit.
- depth, 4: FIFO entries. Must be a power of 2 and at least 2.
- ptr_width, 2: log2(depth).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: upstream offers in_flit this cycle.
- in_flit, input, stream_width: incoming flit.
- in_ready, output, 1: buffer accepts a flit this cycle.
- out_stream, output, stream_width: head flit to the router in_stream lane; zero when empty.
- out_valid, output, 1: out_stream holds a real flit.
- out_ready, input, 1: router/arbiter consumed the head flit this cycle.
- out_naddr, output, net_width: address field of the head flit; zero when empty.
- credit_out, output, 1: one-cycle pulse per dequeue, to the upstream credit counter.
- count, output, ptr_width+1: current occupancy, 0..depth.

Behaviour:
- Reset: on any clk edge with rst=1, the following are cleared:
  - rd_ptr=0, wr_ptr=0, count=0.
  - out_valid=0, out_stream=0, out_naddr=0, credit_out=0.
  - in_ready=1 in the cycle after reset deasserts.
  - rst overrides push and pop in the same cycle.
  - Reset mid-operation discards all stored flits and generates no credits for them.
- Push: push = in_valid & in_ready, with in_ready = (count != depth). in_ready does not depend on out_ready, so there is no combinational path in to out.
- Pop: pop = out_ready & out_valid. out_ready while empty is ignored: no pointer move, no credit.
- Storage: memory indexed by wr_ptr/rd_ptr. Pointers are ptr_width bits and wrap naturally from depth-1 to 0.
- Count update: count += push - pop, applied in a single registered update.
- Simultaneous push and pop: allowed whenever not full; count is unchanged. When full, in_ready=0, so no push can coincide.
- Latency: a flit pushed at edge N is visible on out_stream after edge N, i.e. first-word fall-through with one cycle of latency.
  - out_stream and out_valid are registered.
  - On an empty FIFO with simultaneous push, the new flit appears next cycle; there is no same-cycle bypass.
- Head register update:
  - After a pop, the next entry (or the incoming flit, if it becomes the head) is loaded so back-to-back pops sustain 1 flit/cycle.
  - When the FIFO goes empty, out_stream=0 and out_valid=0 on the same edge.
- out_naddr always equals out_stream[stream_width-1:stream_width-net_width], registered alongside it.
- credit_out: asserted in the cycle following each pop edge, exactly one cycle wide.
- Flit ordering: strictly FIFO; flits are never reordered or duplicated.
- State summary:
  - EMPTY: count=0.
  - PARTIAL: 0<count<depth.
  - FULL: count=depth.
  - Transitions follow push/pop only. FULL to EMPTY requires depth pops.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0 → out_valid=0, out_stream=0, count=0, in_ready=1, credit_out=0.
- Single flit: push flit 0xA followed by zeros (out_naddr=4'hA), out_ready=0 → next cycle out_valid=1, out_naddr=4'hA, count=1. Pulse out_ready → count=0, out_stream=0, credit_out high for exactly 1 cycle.
- Fill to full: 4 pushes with ids 1..4, out_ready=0 → count=4, in_ready=0. A 5th in_valid is not accepted. Then pop 4 times back-to-back → heads 1,2,3,4 in order, 4 credit pulses, count=0.
- Streaming: in_valid=1 and out_ready=1 continuously with ids 1..10 → count stays at most 1 after warm-up, output order 1..10, 10 credits total, no gaps after first output.
- Wrap-around: 3 pushes, 3 pops, then 4 pushes → pointers wrap, heads are returned in push order, count=4.
- Reset mid-operation: count=3, assert rst for 1 cycle with in_valid=1 and out_ready=1 → count=0, out_stream=0, no credit pulse. The flit offered during reset is not stored.
